// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: per channel a one-cycle tick every DIV enabled
// cycles plus a 50%-duty divided level. Divisor writes on a running channel wait for a boundary.
module clock_div_multi #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned W           = 32,
    parameter int unsigned DEFAULT_DIV = 1,
    parameter int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] en,
    input  logic            div_we,
    input  logic [CH_W-1:0] div_ch,
    input  logic [W-1:0]    div_val,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] clk_out,
    output logic [N_CH-1:0] pending
);

    localparam logic [W-1:0] DefDiv = W'(DEFAULT_DIV);

    // A zero divisor would never reach terminal count; clamp it to 1.
    logic [W-1:0] eff_div;
    assign eff_div = (div_val == '0) ? W'(1) : div_val;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [W-1:0] cnt_q, cnt_d;
        logic [W-1:0] cur_q, cur_d;
        logic [W-1:0] pdiv_q, pdiv_d;
        logic         pend_q, pend_d;
        logic         tick_q, tick_d;
        logic         lvl_q, lvl_d;
        logic         wr, term;

        // Out-of-range div_ch never matches any channel index, so the write is dropped.
        assign wr   = div_we && (int'(div_ch) == g);
        assign term = en[g] && (cnt_q == cur_q - W'(1));

        always_comb begin
            cnt_d  = cnt_q;
            cur_d  = cur_q;
            pdiv_d = pdiv_q;
            pend_d = pend_q;
            tick_d = 1'b0;
            lvl_d  = lvl_q;
            if (term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                lvl_d  = ~lvl_q;
                // A write landing on the boundary supersedes any older pending divisor.
                if (wr) begin
                    cur_d  = eff_div;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    cur_d  = pdiv_q;
                    pend_d = 1'b0;
                end
            end else if (en[g]) begin
                cnt_d = cnt_q + W'(1);
                if (wr) begin
                    pdiv_d = eff_div;
                    pend_d = 1'b1;
                end
            end else begin
                // Stopped: apply divisor changes at once and restart the period.
                if (wr) begin
                    cur_d  = eff_div;
                    cnt_d  = '0;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    cur_d  = pdiv_q;
                    cnt_d  = '0;
                    pend_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                cur_q  <= DefDiv;
                pdiv_q <= DefDiv;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                lvl_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                cur_q  <= cur_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                lvl_q  <= lvl_d;
            end
        end

        assign tick[g]    = tick_q;
        assign clk_out[g] = lvl_q;
        assign pending[g] = pend_q;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi: expectations queued as stimulus is driven, then
// popped and compared against the registered outputs one step after each clock edge.
module tb_clock_div_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  en;
    logic        div_we;
    logic [1:0]  div_ch;
    logic [31:0] div_val;
    logic [3:0]  tick, clk_out, pending;

    logic [2:0]  en_s;
    logic        div_we_s;
    logic [1:0]  div_ch_s;
    logic [7:0]  div_val_s;
    logic [2:0]  tick_s, clk_out_s, pending_s;

    clock_div_multi #(.N_CH(4), .W(32), .DEFAULT_DIV(1)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_we  (div_we),
        .div_ch  (div_ch),
        .div_val (div_val),
        .tick    (tick),
        .clk_out (clk_out),
        .pending (pending)
    );

    // Three channels leave div_ch=3 unused, so an out-of-range write can be driven.
    clock_div_multi #(.N_CH(3), .W(8), .DEFAULT_DIV(3)) u_small (
        .clk     (clk),
        .rst     (rst),
        .en      (en_s),
        .div_we  (div_we_s),
        .div_ch  (div_ch_s),
        .div_val (div_val_s),
        .tick    (tick_s),
        .clk_out (clk_out_s),
        .pending (pending_s)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        assert (exp_q.size() != 0) else
            $error("FAIL scoreboard_empty: observed %0h required <queued value>", obs);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert (obs === e.val) begin
                n_pass++;
            end else begin
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_main(input string tag, input logic [3:0] t, input logic [3:0] c,
                            input logic [3:0] p);
        push_exp({tag, ".tick"}, 32'(t));
        push_exp({tag, ".clk_out"}, 32'(c));
        push_exp({tag, ".pending"}, 32'(p));
        step();
        pop_check(32'(tick));
        pop_check(32'(clk_out));
        pop_check(32'(pending));
    endtask

    task automatic cyc_small(input string tag, input logic [2:0] t, input logic [2:0] c,
                             input logic [2:0] p);
        push_exp({tag, ".tick"}, 32'(t));
        push_exp({tag, ".clk_out"}, 32'(c));
        push_exp({tag, ".pending"}, 32'(p));
        step();
        pop_check(32'(tick_s));
        pop_check(32'(clk_out_s));
        pop_check(32'(pending_s));
    endtask

    initial begin
        logic t0, c0, p0;
        rst = 1'b1; en = '0; div_we = 1'b0; div_ch = '0; div_val = '0;
        en_s = '0; div_we_s = 1'b0; div_ch_s = '0; div_val_s = '0;

        // Reset state and divide-by-1 default on all channels.
        step();
        cyc_main("reset", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        en  = 4'hF;
        for (int e = 1; e <= 4; e++)
            cyc_main($sformatf("div1.e%0d", e), 4'hF, (e % 2 == 1) ? 4'hF : 4'h0, 4'h0);

        // Stopped write of 5 to ch1, then run it.
        rst = 1'b1; en = '0;
        step();
        step();
        rst = 1'b0;
        div_we = 1'b1; div_ch = 2'd1; div_val = 32'd5;
        cyc_main("div5.wr", 4'h0, 4'h0, 4'h0);
        div_we = 1'b0;
        en = 4'b0010;
        for (int e = 1; e <= 15; e++)
            cyc_main($sformatf("div5.e%0d", e), {2'b00, e % 5 == 0, 1'b0},
                     {2'b00, (e / 5) % 2 == 1, 1'b0}, 4'h0);

        // ch0 at div 4, rewrite to 7 mid-period: change lands on the old boundary.
        en = '0;
        div_we = 1'b1; div_ch = 2'd0; div_val = 32'd4;
        cyc_main("pend.wr4", 4'h0, 4'b0010, 4'h0);
        en = 4'b0001;
        for (int e = 1; e <= 18; e++) begin
            div_we  = (e == 2);
            div_val = 32'd7;
            t0 = (e == 4) || (e == 11) || (e == 18);
            p0 = (e >= 2) && (e < 4);
            c0 = ((e >= 4) && (e < 11)) || (e >= 18);
            cyc_main($sformatf("pend.e%0d", e), {3'b000, t0}, {3'b001, c0}, {3'b000, p0});
        end
        div_we = 1'b0;

        // Divisor 0 on ch2 behaves as 1 (overwriting a prior 3).
        en = '0;
        div_we = 1'b1; div_ch = 2'd2; div_val = 32'd3;
        cyc_main("zero.wr3", 4'h0, 4'b0011, 4'h0);
        div_val = 32'd0;
        cyc_main("zero.wr0", 4'h0, 4'b0011, 4'h0);
        div_we = 1'b0;
        en = 4'b0100;
        for (int e = 1; e <= 3; e++)
            cyc_main($sformatf("zero.e%0d", e), 4'b0100, {1'b0, e % 2 == 1, 2'b11}, 4'h0);
        en = '0;

        // Out-of-range channel write on the 3-channel instance; DEFAULT_DIV=3 cadence.
        en_s = 3'b111;
        for (int e = 1; e <= 9; e++) begin
            div_we_s = (e == 2); div_ch_s = 2'd3; div_val_s = 8'd1;
            cyc_small($sformatf("oor.e%0d", e), (e % 3 == 0) ? 3'b111 : 3'b000,
                      ((e / 3) % 2 == 1) ? 3'b111 : 3'b000, 3'b000);
        end
        div_we_s = 1'b0; en_s = '0;

        // Write on the exact terminal cycle of ch0 (div 7 -> 2) takes effect immediately.
        en = 4'b0001;
        for (int e = 1; e <= 11; e++) begin
            div_we = (e == 7); div_ch = 2'd0; div_val = 32'd2;
            t0 = (e == 7) || (e == 9) || (e == 11);
            c0 = (e < 7) || ((e >= 9) && (e < 11));
            cyc_main($sformatf("term.e%0d", e), {3'b000, t0}, {3'b011, c0}, 4'h0);
        end
        div_we = 1'b0;

        // ch3 at div 6 with a 3-cycle enable gap at cnt=2, then reset mid-count.
        en = '0;
        div_we = 1'b1; div_ch = 2'd3; div_val = 32'd6;
        cyc_main("stall.wr", 4'h0, 4'b0110, 4'h0);
        div_we = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            en = ((k >= 3) && (k <= 5)) ? 4'b0000 : 4'b1000;
            cyc_main($sformatf("stall.k%0d", k), {k == 9, 3'b000}, {k == 9, 3'b110}, 4'h0);
        end
        en = 4'b1000;
        cyc_main("stall.k10", 4'h0, 4'b1110, 4'h0);
        div_we = 1'b1; div_ch = 2'd3; div_val = 32'd2;
        cyc_main("stall.k11", 4'h0, 4'b1110, 4'b1000);
        div_we = 1'b0;
        rst = 1'b1;
        cyc_main("midrst", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        en = 4'hF;
        cyc_main("midrst.e1", 4'hF, 4'hF, 4'h0);
        cyc_main("midrst.e2", 4'hF, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
